// File: rtl/cache_refill_arbiter_if.sv
// Bundle between the refill arbiter, the two cache miss ports and the main-memory port.
// The slave modport is the arbiter's view; master is the cache/memory side.
interface cache_refill_arbiter_if #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic              imiss;
    logic [ADDR_W-1:0] iaddr;
    logic              dmiss;
    logic [ADDR_W-1:0] daddr;
    logic              ddirty;
    logic [ADDR_W-1:0] dvict_addr;
    logic [DATA_W-1:0] dvict_data;
    logic [IDX_W-1:0]  dvict_idx;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] fill_data;
    logic [IDX_W-1:0]  fill_idx;
    logic              ifill_we;
    logic              dfill_we;
    logic              ifill;
    logic              dfill;

    modport slave (
        input  imiss, iaddr, dmiss, daddr, ddirty, dvict_addr, dvict_data, mem_ack, mem_rdata,
        output dvict_idx, mem_req, mem_we, mem_addr, mem_wdata,
        output fill_data, fill_idx, ifill_we, dfill_we, ifill, dfill
    );

    modport master (
        output imiss, iaddr, dmiss, daddr, ddirty, dvict_addr, dvict_data, mem_ack, mem_rdata,
        input  dvict_idx, mem_req, mem_we, mem_addr, mem_wdata,
        input  fill_data, fill_idx, ifill_we, dfill_we, ifill, dfill
    );
endinterface

// File: rtl/cache_refill_arbiter.sv
// Arbitrates I/D line refills onto one memory port: optional dirty writeback, line read,
// word streaming into the owning cache and a one-cycle completion pulse.
//
// state | meaning
// IDLE  | waiting for a miss; requester completed last cycle is masked
// WB    | writing the dirty D victim line back, one word per ack
// DRD   | reading the D line, one word per ack
// IRD   | reading the I line, one word per ack
// DDONE | last D word strobing into the D-cache; dfill follows
// IDONE | last I word strobing into the I-cache; ifill follows
module cache_refill_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cache_refill_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_WORDS * 4 - 1));

    typedef enum logic [2:0] {IDLE, WB, DRD, IRD, DDONE, IDONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_line_addr;
    logic [ADDR_W-1:0] r_vict_addr;
    logic [DATA_W-1:0] r_fill_data;
    logic [IDX_W-1:0]  r_fill_idx;
    logic              r_ifill_we;
    logic              r_dfill_we;
    logic              r_ifill;
    logic              r_dfill;

    logic              w_busy;
    logic              w_ack;
    logic              w_last;
    logic              w_grant_d;
    logic              w_grant_i;
    logic [ADDR_W-1:0] w_word_off;

    assign w_busy     = (r_state == WB) || (r_state == DRD) || (r_state == IRD);
    assign w_ack      = w_busy && bus.mem_ack;
    assign w_last     = (r_cnt == IDX_W'(LINE_WORDS - 1));
    assign w_word_off = {{(ADDR_W - OFF_W){1'b0}}, r_cnt, 2'b00};
    // The fill pulse register doubles as the one-cycle mask for the stale miss just served.
    assign w_grant_d  = bus.dmiss && !r_dfill;
    assign w_grant_i  = bus.imiss && !r_ifill && !w_grant_d;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_d)      w_state_nxt = bus.ddirty ? WB : DRD;
                else if (w_grant_i) w_state_nxt = IRD;
            end
            WB: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = (r_vict_addr & LINE_MASK) + w_word_off;
                if (w_ack && w_last) w_state_nxt = DRD;
            end
            DRD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = (r_line_addr & LINE_MASK) + w_word_off;
                if (w_ack && w_last) w_state_nxt = DDONE;
            end
            IRD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = (r_line_addr & LINE_MASK) + w_word_off;
                if (w_ack && w_last) w_state_nxt = IDONE;
            end
            DDONE:   w_state_nxt = IDLE;
            IDONE:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_line_addr <= '0;
            r_vict_addr <= '0;
            r_fill_data <= '0;
            r_fill_idx  <= '0;
            r_ifill_we  <= 1'b0;
            r_dfill_we  <= 1'b0;
            r_ifill     <= 1'b0;
            r_dfill     <= 1'b0;
        end else begin
            if (w_ack) r_cnt <= w_last ? '0 : r_cnt + IDX_W'(1);
            if (r_state == IDLE) begin
                if (w_grant_d) begin
                    r_line_addr <= bus.daddr;
                    r_vict_addr <= bus.dvict_addr;
                end else if (w_grant_i) begin
                    r_line_addr <= bus.iaddr;
                end
            end
            if (w_ack && r_state != WB) begin
                r_fill_data <= bus.mem_rdata;
                r_fill_idx  <= r_cnt;
            end
            r_ifill_we <= w_ack && (r_state == IRD);
            r_dfill_we <= w_ack && (r_state == DRD);
            r_ifill    <= (r_state == IDONE);
            r_dfill    <= (r_state == DDONE);
        end
    end

    assign bus.dvict_idx = (r_state == WB) ? r_cnt : '0;
    assign bus.mem_wdata = (r_state == WB) ? bus.dvict_data : '0;
    assign bus.fill_data = r_fill_data;
    assign bus.fill_idx  = r_fill_idx;
    assign bus.ifill_we  = r_ifill_we;
    assign bus.dfill_we  = r_dfill_we;
    assign bus.ifill     = r_ifill;
    assign bus.dfill     = r_dfill;
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Scoreboarded bench: expected memory words, fill words and fill pulses are queued by each
// scenario and retired by the memory model and fill monitors as the arbiter produces them.
module tb_cache_refill_arbiter;
    localparam int LW = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_t;

    typedef struct {
        bit            is_d;
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } fill_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   ack_gap = 0;
    bit   force_ack = 1'b0;
    int   wcnt = 0;
    mem_t  exp_mem[$];
    fill_t exp_fill[$];
    bit    exp_pulse[$];
    int    rises[$];
    int    ipulse_cyc;
    int    dpulse_cyc;
    mem_t  m_e;
    fill_t f_e;
    bit    p_e;

    always #5 clk = ~clk;

    cache_refill_arbiter_if #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_refill_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // D-cache victim array: word k of the victim line holds 0xD0 + k
    assign bus.dvict_data = 32'h0000_00D0 + 32'(bus.dvict_idx);

    logic [105:0] outs;
    assign outs = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.fill_data,
                   bus.fill_idx, bus.dvict_idx, bus.ifill_we, bus.dfill_we, bus.ifill, bus.dfill};

    // Memory model: acks after ack_gap waiting cycles and checks each completed word
    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (wcnt >= ack_gap) begin
                vectors++;
                if (exp_mem.size() == 0) begin
                    miscompares++;
                    $display("FAIL mem_unexpected: we=%b addr=%h, no request required", bus.mem_we, bus.mem_addr);
                    bus.mem_rdata = '0;
                end else begin
                    m_e = exp_mem.pop_front();
                    if (bus.mem_we !== m_e.we || bus.mem_addr !== m_e.addr ||
                        (m_e.we && bus.mem_wdata !== m_e.data)) begin
                        miscompares++;
                        $display("FAIL mem_word: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                 bus.mem_we, bus.mem_addr, bus.mem_wdata, m_e.we, m_e.addr, m_e.data);
                    end
                    bus.mem_rdata = m_e.data;
                end
                bus.mem_ack = 1'b1;
                wcnt = 0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hDEAD_BEEF;
                wcnt++;
            end
        end else begin
            bus.mem_ack   = force_ack;
            bus.mem_rdata = 32'hDEAD_BEEF;
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (bus.ifill_we || bus.dfill_we) begin
            vectors++;
            if (bus.ifill_we && bus.dfill_we) begin
                miscompares++;
                $display("FAIL fill_we_exclusive: ifill_we=1 dfill_we=1, required one of them");
            end else if (exp_fill.size() == 0) begin
                miscompares++;
                $display("FAIL fill_unexpected: got dfill_we=%b idx=%0d data=%h, required none",
                         bus.dfill_we, bus.fill_idx, bus.fill_data);
            end else begin
                f_e = exp_fill.pop_front();
                if (bus.dfill_we !== f_e.is_d || bus.fill_idx !== f_e.idx || bus.fill_data !== f_e.data) begin
                    miscompares++;
                    $display("FAIL fill_word: got dfill_we=%b idx=%0d data=%h, required dfill_we=%b idx=%0d data=%h",
                             bus.dfill_we, bus.fill_idx, bus.fill_data, f_e.is_d, f_e.idx, f_e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.ifill || bus.dfill) begin
            vectors++;
            if (bus.ifill && bus.dfill) begin
                miscompares++;
                $display("FAIL pulse_exclusive: ifill=1 dfill=1, required one of them");
            end else if (exp_pulse.size() == 0) begin
                miscompares++;
                $display("FAIL pulse_unexpected: got dfill=%b ifill=%b, required none", bus.dfill, bus.ifill);
            end else begin
                p_e = exp_pulse.pop_front();
                if (bus.dfill !== p_e) begin
                    miscompares++;
                    $display("FAIL pulse_owner: got dfill=%b ifill=%b, required dfill=%b", bus.dfill, bus.ifill, p_e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_read(input bit is_d, input logic [AW-1:0] base, input logic [DW-1:0] d0);
        mem_t  m;
        fill_t f;
        for (int k = 0; k < LW; k++) begin
            m.we   = 1'b0;
            m.addr = base + 32'(4 * k);
            m.data = d0 + 32'(k);
            exp_mem.push_back(m);
            f.is_d = is_d;
            f.idx  = 2'(k);
            f.data = d0 + 32'(k);
            exp_fill.push_back(f);
        end
    endtask

    task automatic push_wb(input logic [AW-1:0] base);
        mem_t m;
        for (int k = 0; k < LW; k++) begin
            m.we   = 1'b1;
            m.addr = base + 32'(4 * k);
            m.data = 32'h0000_00D0 + 32'(k);
            exp_mem.push_back(m);
        end
    endtask

    // Runs until every queued expectation retires, acting as the stall unit: a miss line is
    // dropped one cycle after its fill pulse, so it is still high at the masked grant edge.
    task automatic wait_done(input int budget);
        int n;
        bit drop_i;
        bit drop_d;
        bit prev_req;
        n = 0;
        drop_i = 1'b0;
        drop_d = 1'b0;
        rises.delete();
        ipulse_cyc = -1;
        dpulse_cyc = -1;
        prev_req = bus.mem_req;
        while ((exp_mem.size() != 0 || exp_fill.size() != 0 || exp_pulse.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (drop_i) bus.imiss = 1'b0;
            if (drop_d) bus.dmiss = 1'b0;
            drop_i = bus.ifill;
            drop_d = bus.dfill;
            if (bus.mem_req && !prev_req) rises.push_back(n);
            prev_req = bus.mem_req;
            if (bus.ifill) ipulse_cyc = n;
            if (bus.dfill) dpulse_cyc = n;
        end
        if (exp_mem.size() != 0 || exp_fill.size() != 0 || exp_pulse.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: pending mem=%0d fill=%0d pulse=%0d, required 0",
                     exp_mem.size(), exp_fill.size(), exp_pulse.size());
            exp_mem.delete();
            exp_fill.delete();
            exp_pulse.delete();
        end
        repeat (4) begin
            @(negedge clk);
            #1;
            if (drop_i) bus.imiss = 1'b0;
            if (drop_d) bus.dmiss = 1'b0;
            drop_i = bus.ifill;
            drop_d = bus.dfill;
        end
    endtask

    task automatic test_reset;
        bus.imiss = 1'b1;
        bus.iaddr = 32'h0000_0500;
        force_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (outs !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %h, required 0", outs);
            end
        end
        ack_gap = 0;
        push_read(1'b0, 32'h0000_0500, 32'h0000_0050);
        exp_pulse.push_back(1'b0);
        force_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_req: got mem_req=%b, required 1", bus.mem_req);
        end
        wait_done(100);
    endtask

    task automatic test_i_refill;
        ack_gap = 2;
        bus.iaddr = 32'h0000_104C;
        push_read(1'b0, 32'h0000_1040, 32'h0000_00A0);
        exp_pulse.push_back(1'b0);
        @(negedge clk);
        #1;
        bus.imiss = 1'b1;
        wait_done(200);
        vectors++;
        if (rises.size() != 1 || rises[0] != 1) begin
            miscompares++;
            $display("FAIL i_grant_latency: got %0d request starts (first at %0d), required 1 at cycle 1",
                     rises.size(), (rises.size() != 0) ? rises[0] : -1);
        end
    endtask

    task automatic test_dirty_d_refill;
        ack_gap = 1;
        bus.ddirty = 1'b1;
        bus.dvict_addr = 32'h0000_2000;
        bus.daddr = 32'h0000_3008;
        push_wb(32'h0000_2000);
        push_read(1'b1, 32'h0000_3000, 32'h0000_00B0);
        exp_pulse.push_back(1'b1);
        @(negedge clk);
        #1;
        bus.dmiss = 1'b1;
        wait_done(200);
        bus.ddirty = 1'b0;
        vectors++;
        if (rises.size() != 1 || rises[0] != 1) begin
            miscompares++;
            $display("FAIL wb_to_read_gap: got %0d request starts, required 1 continuous burst from cycle 1",
                     rises.size());
        end
    endtask

    task automatic test_simultaneous;
        ack_gap = 0;
        bus.ddirty = 1'b0;
        bus.daddr = 32'h0000_4014;
        bus.iaddr = 32'h0000_5004;
        push_read(1'b1, 32'h0000_4010, 32'h0000_00C0);
        push_read(1'b0, 32'h0000_5000, 32'h0000_00E0);
        exp_pulse.push_back(1'b1);
        exp_pulse.push_back(1'b0);
        @(negedge clk);
        #1;
        bus.imiss = 1'b1;
        bus.dmiss = 1'b1;
        wait_done(300);
        vectors++;
        if (rises.size() != 2 || rises[1] != dpulse_cyc + 1) begin
            miscompares++;
            $display("FAIL i_grant_after_dfill: got %0d request starts (dfill at %0d), required I start at dfill+1",
                     rises.size(), dpulse_cyc);
        end
    endtask

    task automatic test_late_d_miss;
        int n;
        ack_gap = 1;
        bus.ddirty = 1'b0;
        bus.iaddr = 32'h0000_6008;
        bus.daddr = 32'h0000_7000;
        push_read(1'b0, 32'h0000_6000, 32'h0000_00F0);
        push_read(1'b1, 32'h0000_7000, 32'h0000_0090);
        exp_pulse.push_back(1'b0);
        exp_pulse.push_back(1'b1);
        @(negedge clk);
        #1;
        bus.imiss = 1'b1;
        n = 0;
        while (exp_mem.size() != 7 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #1;
        bus.dmiss = 1'b1;
        wait_done(300);
        vectors++;
        if (rises.size() != 1 || rises[0] != ipulse_cyc + 1) begin
            miscompares++;
            $display("FAIL d_grant_after_ifill: got %0d request starts (ifill at %0d), required D start at ifill+1",
                     rises.size(), ipulse_cyc);
        end
    endtask

    task automatic test_reset_mid_op;
        int n;
        ack_gap = 2;
        bus.iaddr = 32'h0000_8004;
        push_read(1'b0, 32'h0000_8000, 32'h0000_0070);
        void'(exp_mem.pop_back());
        void'(exp_mem.pop_back());
        void'(exp_fill.pop_back());
        void'(exp_fill.pop_back());
        @(negedge clk);
        #1;
        bus.imiss = 1'b1;
        n = 0;
        while (exp_mem.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (outs !== '0 || exp_fill.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_op: got outputs %h with %0d fills pending, required 0 and 0",
                     outs, exp_fill.size());
        end
        push_read(1'b0, 32'h0000_8000, 32'h0000_0060);
        exp_pulse.push_back(1'b0);
        rst_n = 1'b1;
        wait_done(200);
        vectors++;
        if (rises.size() != 1 || rises[0] != 1) begin
            miscompares++;
            $display("FAIL restart_after_reset: got %0d request starts, required 1 at cycle 1", rises.size());
        end
    endtask

    initial begin
        bus.imiss = 1'b0;
        bus.iaddr = '0;
        bus.dmiss = 1'b0;
        bus.daddr = '0;
        bus.ddirty = 1'b0;
        bus.dvict_addr = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        rst_n = 1'b0;
        test_reset();
        test_i_refill();
        test_dirty_d_refill();
        test_simultaneous();
        test_late_d_miss();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
